// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector:
//   - fill_state_t : FILL while fewer than LEN bits are valid, ARMED once full
//   - LEN_MIN/LEN_MAX : supported pattern length range
//   - FILL_W : width of the fill counter (must hold 0..LEN_MAX)
//   - DEFAULT_PATTERN : default pattern, right-aligned in LEN_MAX bits
//   - pattern_width() : number of significant bits in a pattern constant
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_t;

    localparam int LEN_MIN = 1;
    localparam int LEN_MAX = 16;
    localparam int FILL_W  = 5;

    localparam logic [LEN_MAX-1:0] DEFAULT_PATTERN = 16'b101;

    // Position of the highest set bit plus one; 0 for an all-zero pattern.
    // Used at elaboration to reject patterns that do not fit in LEN bits.
    function automatic int pattern_width(input logic [LEN_MAX-1:0] pat);
        int width;
        width = 0;
        for (int k = 0; k < LEN_MAX; k++) begin
            if (pat[k]) begin
                width = k + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// -----------------------------------------------------------------------------
// seq_det_shreg
// LEN-bit history shift register plus a fill counter that tracks how many of
// the history bits are valid since the last reset or clear.
// The next-state values are exported so the parent can evaluate the match
// condition on the same edge that samples the final pattern bit.
//
// Ports:
//   i_clk       in   1        clock, all state on posedge
//   i_rst_n     in   1        synchronous active-low reset (clears everything)
//   i_clr       in   1        synchronous clear of the fill count only
//   i_din       in   1        serial data bit
//   o_hist_next out  LEN      history after shifting in i_din (newest = LSB)
//   o_fill_next out  FILL_W   fill count after this edge, saturating at LEN
//   o_state     out  1        registered FILL/ARMED state
// -----------------------------------------------------------------------------
module seq_det_shreg
    import seq_det_pkg::*;
#(
    parameter int LEN = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_din,
    output logic [LEN-1:0]    o_hist_next,
    output logic [FILL_W-1:0] o_fill_next,
    output fill_state_t       o_state
);

    localparam logic [FILL_W-1:0] LEN_F = FILL_W'(LEN);

    logic [LEN-1:0]    r_hist;
    logic [FILL_W-1:0] r_fill;
    fill_state_t       r_state;

    // Oldest bit drops off the top; the cast keeps the lower LEN bits and
    // also covers LEN==1, where the history is just the newest bit.
    assign o_hist_next = LEN'({r_hist, i_din});

    // Once ARMED the count is pinned at LEN.
    assign o_fill_next = (r_state == ARMED) ? LEN_F : (r_fill + 1'b1);

    assign o_state = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= FILL;
        end else begin
            r_hist <= o_hist_next;
            if (i_clr) begin
                // History bits are left in place but become invalid.
                r_fill  <= '0;
                r_state <= FILL;
            end else begin
                r_fill  <= o_fill_next;
                r_state <= (o_fill_next == LEN_F) ? ARMED : FILL;
            end
        end
    end

endmodule

// File: rtl/seq_det.sv
// -----------------------------------------------------------------------------
// seq_det
// Serial bit-pattern detector. One bit of B is sampled per Clk edge; w pulses
// high for one cycle after the edge that completes a LEN-bit match against
// PATTERN (PATTERN[LEN-1] is the first bit received).
//
// Optional feature: define SEQ_DET_COUNT_EN to add the match_cnt port, a
// saturating count of matches cleared only by reset.
//
// Parameters:
//   LEN      pattern length, 1..16
//   PATTERN  pattern, right-aligned; must fit in LEN bits
//   OVERLAP  1: matches may share bits; 0: history invalidated after a match
//   CNT_W    match counter width (used with SEQ_DET_COUNT_EN)
//
// Ports:
//   Clk        in   1      clock, all logic on posedge
//   Rst        in   1      synchronous active-low reset, priority over B
//   B          in   1      serial data, assumed synchronous to Clk
//   w          out  1      registered match pulse
//   match_cnt  out  CNT_W  saturating match count (SEQ_DET_COUNT_EN only)
// -----------------------------------------------------------------------------
module seq_det
    import seq_det_pkg::*;
#(
    parameter int                 LEN     = 3,
    parameter logic [LEN_MAX-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             B,
    output logic             w
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    generate
        if ((LEN < LEN_MIN) || (LEN > LEN_MAX)) begin : g_bad_len
            $error("seq_det: LEN=%0d outside %0d..%0d", LEN, LEN_MIN, LEN_MAX);
        end
        if (pattern_width(PATTERN) > LEN) begin : g_bad_pattern
            $error("seq_det: PATTERN wider than LEN=%0d", LEN);
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("seq_det: CNT_W=%0d must be at least 1", CNT_W);
        end
    endgenerate

    localparam logic [FILL_W-1:0] LEN_F   = FILL_W'(LEN);
    localparam logic [LEN-1:0]    PAT_LEN = PATTERN[LEN-1:0];

    logic [LEN-1:0]    w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    fill_state_t       w_state;
    logic              w_match;
    logic              w_clr;
    logic              r_w;

    seq_det_shreg #(
        .LEN (LEN)
    ) u_shreg (
        .i_clk       (Clk),
        .i_rst_n     (Rst),
        .i_clr       (w_clr),
        .i_din       (B),
        .o_hist_next (w_hist_next),
        .o_fill_next (w_fill_next),
        .o_state     (w_state)
    );

    // Match is judged on the post-shift view so w can register it on the
    // same edge that samples the last pattern bit (latency of one cycle).
    assign w_match = (w_fill_next == LEN_F) && (w_hist_next == PAT_LEN);

    // Without overlap, a match forces LEN fresh bits before the next one.
    assign w_clr = w_match && (OVERLAP == 1'b0);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_w <= 1'b0;
        end else begin
            r_w <= w_match;
        end
    end

    assign w = r_w;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;

    // The FILL/ARMED state is only informative here; keep it referenced.
    logic w_state_unused;
    assign w_state_unused = (w_state == ARMED);
`else
    logic w_state_unused;
    assign w_state_unused = (w_state == ARMED);
`endif

endmodule

// File: tb/tb_seq_det.sv
// -----------------------------------------------------------------------------
// tb_seq_det
// Three detector instances share Clk/Rst/B:
//   dut0 : LEN=3 PATTERN=101  OVERLAP=1 CNT_W=2
//   dut1 : LEN=3 PATTERN=101  OVERLAP=0
//   dut2 : LEN=4 PATTERN=1101 OVERLAP=1
// Reference model: per instance, a queue of bits received since reset (or
// since the last match when overlap is off); a match is "queue holds at least
// LEN bits and its last LEN bits spell the pattern".
// -----------------------------------------------------------------------------
module tb_seq_det;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic B   = 1'b0;
    logic w0, w1, w2;
`ifdef SEQ_DET_COUNT_EN
    logic [1:0] cnt0;
    logic [7:0] cnt1, cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    seq_det #(.LEN(3), .PATTERN(16'b101), .OVERLAP(1'b1), .CNT_W(2)) dut0 (
        .Clk(Clk), .Rst(Rst), .B(B), .w(w0)
`ifdef SEQ_DET_COUNT_EN
        , .match_cnt(cnt0)
`endif
    );
    seq_det #(.LEN(3), .PATTERN(16'b101), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
        .Clk(Clk), .Rst(Rst), .B(B), .w(w1)
`ifdef SEQ_DET_COUNT_EN
        , .match_cnt(cnt1)
`endif
    );
    seq_det #(.LEN(4), .PATTERN(16'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut2 (
        .Clk(Clk), .Rst(Rst), .B(B), .w(w2)
`ifdef SEQ_DET_COUNT_EN
        , .match_cnt(cnt2)
`endif
    );

    // ---------------- reference model ----------------
    bit q0[$];
    bit q1[$];
    bit q2[$];
    bit e_w0, e_w1, e_w2;
    int e_c0, e_c1, e_c2;

    function automatic bit seen(input bit q[$], input int len, input bit [15:0] pat);
        if (q.size() < len) return 1'b0;
        for (int k = 0; k < len; k++) begin
            if (q[q.size() - len + k] != pat[len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: drive on the falling edge, update the model at the rising
    // edge, leave the caller 1 time unit after the edge to sample outputs.
    task automatic step(input bit rst_n, input bit b);
        @(negedge Clk);
        Rst = rst_n;
        B   = b;
        @(posedge Clk);
        if (!rst_n) begin
            q0.delete(); q1.delete(); q2.delete();
            e_w0 = 0; e_w1 = 0; e_w2 = 0;
            e_c0 = 0; e_c1 = 0; e_c2 = 0;
        end else begin
            q0.push_back(b); q1.push_back(b); q2.push_back(b);
            e_w0 = seen(q0, 3, 16'b101);
            e_w1 = seen(q1, 3, 16'b101);
            e_w2 = seen(q2, 4, 16'b1101);
            if (e_w1) q1.delete();
            if (e_w0 && e_c0 < 3)   e_c0++;
            if (e_w1 && e_c1 < 255) e_c1++;
            if (e_w2 && e_c2 < 255) e_c2++;
            while (q0.size() > 16) void'(q0.pop_front());
            while (q1.size() > 16) void'(q1.pop_front());
            while (q2.size() > 16) void'(q2.pop_front());
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            n_tests++;
            if ({w0, w1, w2} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset edge%0d: w0,w1,w2=%b%b%b expected 000", i + 1, w0, w1, w2);
            end
`ifdef SEQ_DET_COUNT_EN
            n_tests++;
            if (cnt0 !== 2'd0 || cnt1 !== 8'd0 || cnt2 !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_cnt edge%0d: cnt=%0d,%0d,%0d expected 0,0,0", i + 1, cnt0, cnt1, cnt2);
            end
`endif
        end
    endtask

    task automatic test_basic();
        bit b_seq[4] = '{1, 0, 1, 0};
        bit exp_w[4] = '{0, 0, 1, 0};
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b_seq[i]);
            n_tests++;
            if (w0 !== exp_w[i]) begin
                n_fail++;
                $display("FAIL basic_ov edge%0d: w=%b expected %b", i + 1, w0, exp_w[i]);
            end
            n_tests++;
            if (w1 !== exp_w[i]) begin
                n_fail++;
                $display("FAIL basic_noov edge%0d: w=%b expected %b", i + 1, w1, exp_w[i]);
            end
        end
    endtask

    task automatic test_overlap();
        bit b_seq[5]  = '{1, 0, 1, 0, 1};
        bit exp_ov[5] = '{0, 0, 1, 0, 1};
        bit exp_no[5] = '{0, 0, 1, 0, 0};
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, b_seq[i]);
            n_tests++;
            if (w0 !== exp_ov[i]) begin
                n_fail++;
                $display("FAIL overlap1 edge%0d: w=%b expected %b", i + 1, w0, exp_ov[i]);
            end
            n_tests++;
            if (w1 !== exp_no[i]) begin
                n_fail++;
                $display("FAIL overlap0 edge%0d: w=%b expected %b", i + 1, w1, exp_no[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit r_seq[6] = '{1, 1, 0, 1, 1, 1};
        bit b_seq[6] = '{1, 0, 0, 1, 1, 0};
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(r_seq[i], b_seq[i]);
            n_tests++;
            if ({w0, w1} !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_reset edge%0d: w0,w1=%b%b expected 00", i + 1, w0, w1);
            end
        end
    endtask

    task automatic test_len4();
        bit b_a[4]   = '{1, 1, 0, 1};
        bit exp_a[4] = '{0, 0, 0, 1};
        bit b_b[5]   = '{1, 1, 1, 0, 1};
        bit exp_b[5] = '{0, 0, 0, 0, 1};
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b_a[i]);
            n_tests++;
            if (w2 !== exp_a[i]) begin
                n_fail++;
                $display("FAIL len4_a edge%0d: w=%b expected %b", i + 1, w2, exp_a[i]);
            end
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, b_b[i]);
            n_tests++;
            if (w2 !== exp_b[i]) begin
                n_fail++;
                $display("FAIL len4_b edge%0d: w=%b expected %b", i + 1, w2, exp_b[i]);
            end
        end
    endtask

`ifdef SEQ_DET_COUNT_EN
    task automatic test_count();
        bit       grp[5] = '{1, 0, 1, 0, 0};
        bit [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, 1'b0);
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 5; i++) begin
                step(1'b1, grp[i]);
            end
            n_tests++;
            if (cnt0 !== exp_c[m]) begin
                n_fail++;
                $display("FAIL count match%0d: cnt=%0d expected %0d", m + 1, cnt0, exp_c[m]);
            end
        end
        step(1'b0, 1'b0);
        n_tests++;
        if (cnt0 !== 2'd0) begin
            n_fail++;
            $display("FAIL count_reset: cnt=%0d expected 0", cnt0);
        end
    endtask
`endif

    task automatic test_random();
        step(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)));
            n_tests++;
            if ({w0, w1, w2} !== {e_w0, e_w1, e_w2}) begin
                n_fail++;
                $display("FAIL random step%0d: w0,w1,w2=%b%b%b expected %b%b%b",
                         i, w0, w1, w2, e_w0, e_w1, e_w2);
            end
`ifdef SEQ_DET_COUNT_EN
            n_tests++;
            if (cnt0 !== 2'(e_c0) || cnt1 !== 8'(e_c1) || cnt2 !== 8'(e_c2)) begin
                n_fail++;
                $display("FAIL random_cnt step%0d: cnt=%0d,%0d,%0d expected %0d,%0d,%0d",
                         i, cnt0, cnt1, cnt2, e_c0, e_c1, e_c2);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_mid_reset();
        test_len4();
`ifdef SEQ_DET_COUNT_EN
        test_count();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
